// File: rtl/regs_mp_pkg.sv
// Shared defaults, FSM state encoding and the packed read-port slice macro for regs_mp.
`ifndef REGS_MP_PKG_SV
`define REGS_MP_PKG_SV

`define REGS_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package regs_mp_pkg;
   localparam int XLEN_DEF       = 32;
   localparam int REG_COUNT_DEF  = 32;
   localparam int READ_PORTS_DEF = 3;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;
endpackage

`endif

// File: rtl/regs_mp_bypass.sv
// One read port of regs_mp: zero/wr0/wr1/array priority mux and bypassed busy flag.
module regs_bypass #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              i_run,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic [XLEN-1:0]   i_arr_data,
   input  logic              i_busy,
   input  logic              i_wr0_en,
   input  logic [ADDR_W-1:0] i_wr0_addr,
   input  logic [XLEN-1:0]   i_wr0_data,
   input  logic              i_wr1_en,
   input  logic [ADDR_W-1:0] i_wr1_addr,
   input  logic [XLEN-1:0]   i_wr1_data,
   output logic [XLEN-1:0]   o_rd_data,
   output logic              o_rd_busy
);
   logic w_hit0;
   logic w_hit1;

   assign w_hit0 = i_wr0_en && (i_wr0_addr == i_rd_addr);
   assign w_hit1 = i_wr1_en && (i_wr1_addr == i_rd_addr);

   always_comb begin
      o_rd_data = '0;
      if (i_run && (i_rd_addr != '0)) begin
         if (w_hit0)
            o_rd_data = i_wr0_data;
         else if (w_hit1)
            o_rd_data = i_wr1_data;
         else
            o_rd_data = i_arr_data;
      end
   end

   // A write landing this cycle retires the pending producer before the edge.
   assign o_rd_busy = i_run && i_busy && !(w_hit0 || w_hit1);
endmodule

// File: rtl/regs_mp.sv
// Multi-port integer register file with dual write, bypassed reads, scoreboard and clear sweep.
// Optional raw debug read port enabled by defining REGS_DEBUG_PORT_EN.
//
// state   | meaning
// --------+---------------------------------------------------
// ST_INIT | clear sweep: zero data[cnt] each cycle, ignore writes/issues
// ST_RUN  | normal operation, ready = 1
module regs_mp
   import regs_mp_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int REG_COUNT  = REG_COUNT_DEF,
   parameter int READ_PORTS = READ_PORTS_DEF,
   parameter int ADDR_W     = $clog2(REG_COUNT)
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         ready,
   input  logic [READ_PORTS*ADDR_W-1:0] rd_addr,
   output logic [READ_PORTS*XLEN-1:0]   rd_data,
   output logic [READ_PORTS-1:0]        rd_busy,
   input  logic                         wr0_en,
   input  logic [ADDR_W-1:0]            wr0_addr,
   input  logic [XLEN-1:0]              wr0_data,
   input  logic                         wr1_en,
   input  logic [ADDR_W-1:0]            wr1_addr,
   input  logic [XLEN-1:0]              wr1_data,
   input  logic                         issue_en,
   input  logic [ADDR_W-1:0]            issue_addr,
   output logic [REG_COUNT-1:0]         busy
`ifdef REGS_DEBUG_PORT_EN
   ,
   input  logic [ADDR_W-1:0]            dbg_addr,
   output logic [XLEN-1:0]              dbg_data
`endif
);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ADDR_W-1:0]    r_cnt;
   logic [ADDR_W-1:0]    w_cnt_nxt;
   logic [REG_COUNT-1:0] r_busy;
   logic [REG_COUNT-1:0] w_busy_nxt;
   logic [XLEN-1:0]      r_data [REG_COUNT];
   logic                 w_run;

   assign w_run = (r_state == ST_RUN);
   assign ready = w_run;
   assign busy  = r_busy;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
         r_busy  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_busy_nxt  = r_busy;
      case (r_state)
         ST_INIT: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == LAST_IDX)
               w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // Clear first, then set, so a same-cycle issue marks the new producer.
            for (int i = 1; i < REG_COUNT; i++) begin
               if ((wr0_en && (wr0_addr == ADDR_W'(i))) ||
                   (wr1_en && (wr1_addr == ADDR_W'(i))))
                  w_busy_nxt[i] = 1'b0;
               if (issue_en && (issue_addr == ADDR_W'(i)))
                  w_busy_nxt[i] = 1'b1;
            end
            w_busy_nxt[0] = 1'b0;
         end
         default: w_state_nxt = ST_INIT;
      endcase
   end

   // wr0 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (r_state == ST_INIT) begin
            r_data[r_cnt] <= '0;
         end else begin
            if (wr1_en && (wr1_addr != '0))
               r_data[wr1_addr] <= wr1_data;
            if (wr0_en && (wr0_addr != '0))
               r_data[wr0_addr] <= wr0_data;
         end
      end
   end

   for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      assign w_addr = `REGS_SLICE(rd_addr, gi, ADDR_W);

      regs_bypass #(
         .XLEN   (XLEN),
         .ADDR_W (ADDR_W)
      ) u_bypass (
         .i_run      (w_run),
         .i_rd_addr  (w_addr),
         .i_arr_data (r_data[w_addr]),
         .i_busy     (r_busy[w_addr]),
         .i_wr0_en   (wr0_en),
         .i_wr0_addr (wr0_addr),
         .i_wr0_data (wr0_data),
         .i_wr1_en   (wr1_en),
         .i_wr1_addr (wr1_addr),
         .i_wr1_data (wr1_data),
         .o_rd_data  (`REGS_SLICE(rd_data, gi, XLEN)),
         .o_rd_busy  (rd_busy[gi])
      );
   end

`ifdef REGS_DEBUG_PORT_EN
   assign dbg_data = w_run ? r_data[dbg_addr] : '0;
`endif
endmodule

// File: tb/tb_regs_mp.sv
// Self-checking bench for regs_mp: directed vector table, reset/sweep sequences, random run vs model.
`timescale 1ns/1ps
module tb_regs_mp;
   localparam int XLEN = 32;
   localparam int REG_COUNT = 32;
   localparam int READ_PORTS = 3;
   localparam int ADDR_W = 5;

   logic                         clk = 1'b0;
   logic                         rst = 1'b0;
   logic                         ready;
   logic [READ_PORTS*ADDR_W-1:0] rd_addr = '0;
   logic [READ_PORTS*XLEN-1:0]   rd_data;
   logic [READ_PORTS-1:0]        rd_busy;
   logic                         wr0_en = 1'b0;
   logic [ADDR_W-1:0]            wr0_addr = '0;
   logic [XLEN-1:0]              wr0_data = '0;
   logic                         wr1_en = 1'b0;
   logic [ADDR_W-1:0]            wr1_addr = '0;
   logic [XLEN-1:0]              wr1_data = '0;
   logic                         issue_en = 1'b0;
   logic [ADDR_W-1:0]            issue_addr = '0;
   logic [REG_COUNT-1:0]         busy;
`ifdef REGS_DEBUG_PORT_EN
   logic [ADDR_W-1:0]            dbg_addr = '0;
   logic [XLEN-1:0]              dbg_data;
`endif

   regs_mp dut (
      .clk        (clk),
      .rst        (rst),
      .ready      (ready),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .wr0_en     (wr0_en),
      .wr0_addr   (wr0_addr),
      .wr0_data   (wr0_data),
      .wr1_en     (wr1_en),
      .wr1_addr   (wr1_addr),
      .wr1_data   (wr1_data),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .busy       (busy)
`ifdef REGS_DEBUG_PORT_EN
      ,
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: architectural register values and pending-producer set.
   logic [XLEN-1:0]      m_data [REG_COUNT];
   logic [REG_COUNT-1:0] m_busy;

   typedef struct {
      logic                         w0e;
      logic [ADDR_W-1:0]            w0a;
      logic [XLEN-1:0]              w0d;
      logic                         w1e;
      logic [ADDR_W-1:0]            w1a;
      logic [XLEN-1:0]              w1d;
      logic                         ie;
      logic [ADDR_W-1:0]            ia;
      logic [READ_PORTS*ADDR_W-1:0] ra;
      logic [READ_PORTS*XLEN-1:0]   exp_rd;
      logic [READ_PORTS-1:0]        exp_rb;
      logic [REG_COUNT-1:0]         exp_busy;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] m_read(input logic [ADDR_W-1:0] a);
      if (a == 0) return '0;
      if (wr0_en && wr0_addr == a) return wr0_data;
      if (wr1_en && wr1_addr == a) return wr1_data;
      return m_data[a];
   endfunction

   function automatic logic m_rbusy(input logic [ADDR_W-1:0] a);
      logic written;
      written = (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
      return m_busy[a] && !written;
   endfunction

   task automatic m_commit();
      if (wr1_en && wr1_addr != 0) m_data[wr1_addr] = wr1_data;
      if (wr0_en && wr0_addr != 0) m_data[wr0_addr] = wr0_data;
      if (wr0_en) m_busy[wr0_addr] = 1'b0;
      if (wr1_en) m_busy[wr1_addr] = 1'b0;
      if (issue_en) m_busy[issue_addr] = 1'b1;
      m_busy[0] = 1'b0;
   endtask

   task automatic m_reset();
      for (int a = 0; a < REG_COUNT; a++) m_data[a] = '0;
      m_busy = '0;
   endtask

   task automatic set_idle();
      wr0_en = 1'b0; wr1_en = 1'b0; issue_en = 1'b0;
   endtask

   function automatic logic [ADDR_W-1:0] rnd_addr();
      if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 7));
      return ADDR_W'($urandom_range(0, REG_COUNT - 1));
   endfunction

   // Called just after a falling edge with inputs already driven.
   task automatic model_cycle();
      logic [ADDR_W-1:0] a;
      #1;
      for (int p = 0; p < READ_PORTS; p++) begin
         a = rd_addr[p*ADDR_W +: ADDR_W];
         chk($sformatf("rd_data[%0d] x%0d", p, a), 64'(rd_data[p*XLEN +: XLEN]), 64'(m_read(a)));
         chk($sformatf("rd_busy[%0d] x%0d", p, a), 64'(rd_busy[p]), 64'(m_rbusy(a)));
      end
`ifdef REGS_DEBUG_PORT_EN
      chk("dbg_data", 64'(dbg_data), 64'(m_data[dbg_addr]));
`endif
      @(posedge clk);
      m_commit();
      #1;
      chk("busy", 64'(busy), 64'(m_busy));
      @(negedge clk);
   endtask

   // Holds rst low, releases it, and times the sweep while junk traffic is applied.
   task automatic do_reset(input int low_cycles);
      int n;
      @(negedge clk);
      rst = 1'b0;
      wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'hFFFF_0000;
      wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h0000_FFFF;
      issue_en = 1'b1; issue_addr = 5'd2;
      rd_addr = {5'd2, 5'd3, 5'd2};
      repeat (low_cycles) @(posedge clk);
      #1;
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      while (n <= 40) begin
         @(posedge clk);
         #1;
         n++;
         if (ready) break;
         chk("init_rd_data", 64'(rd_data[XLEN-1:0]), 64'd0);
         chk("init_rd_busy", 64'(rd_busy), 64'd0);
      end
      chk("sweep_latency", 64'(n), 64'(REG_COUNT));
      set_idle();
      m_reset();
      for (int a = 0; a < REG_COUNT; a++) begin
         rd_addr = {ADDR_W'(a), ADDR_W'(a), ADDR_W'(a)};
         #1;
         chk($sformatf("sweep_zero x%0d", a), 64'(rd_data[(a % READ_PORTS)*XLEN +: XLEN]), 64'd0);
      end
      chk("post_sweep_busy", 64'(busy), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd5, 5'd0, 5'd5},
                  {32'hDEADBEEF, 32'h0, 32'hDEADBEEF}, 3'b000, 32'h0};
      tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd4, 5'd3, 5'd5},
                  {32'h0, 32'h0, 32'hDEADBEEF}, 3'b000, 32'h0};
      tbl[2]  = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, {5'd5, 5'd4, 5'd3},
                  {32'hDEADBEEF, 32'h22, 32'h11}, 3'b000, 32'h0};
      tbl[3]  = '{1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, {5'd4, 5'd3, 5'd7},
                  {32'h22, 32'h11, 32'hAA}, 3'b000, 32'h0};
      tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd4, 5'd3, 5'd7},
                  {32'h22, 32'h11, 32'hAA}, 3'b000, 32'h0};
      tbl[5]  = '{1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, {5'd7, 5'd0, 5'd0},
                  {32'hAA, 32'h0, 32'h0}, 3'b000, 32'h0};
      tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd0, 5'd0, 5'd0},
                  {32'h0, 32'h0, 32'h0}, 3'b000, 32'h0};
      tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, {5'd9, 5'd9, 5'd9},
                  {32'h0, 32'h0, 32'h0}, 3'b000, 32'h200};
      tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd0, 5'd9, 5'd9},
                  {32'h0, 32'h0, 32'h0}, 3'b011, 32'h200};
      tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, {5'd5, 5'd9, 5'd9},
                  {32'hDEADBEEF, 32'h99, 32'h99}, 3'b000, 32'h0};
      tbl[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd9, 5'd9, 5'd9},
                  {32'h99, 32'h99, 32'h99}, 3'b000, 32'h0};
      tbl[11] = '{1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, {5'd9, 5'd9, 5'd9},
                  {32'h77, 32'h77, 32'h77}, 3'b000, 32'h200};
      tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd9, 5'd3, 5'd9},
                  {32'h77, 32'h11, 32'h77}, 3'b101, 32'h200};

      do_reset(3);

      for (int v = 0; v < 13; v++) begin
         wr0_en = tbl[v].w0e; wr0_addr = tbl[v].w0a; wr0_data = tbl[v].w0d;
         wr1_en = tbl[v].w1e; wr1_addr = tbl[v].w1a; wr1_data = tbl[v].w1d;
         issue_en = tbl[v].ie; issue_addr = tbl[v].ia;
         rd_addr = tbl[v].ra;
         #1;
         for (int p = 0; p < READ_PORTS; p++)
            chk($sformatf("vec%0d rd_data[%0d]", v, p), 64'(rd_data[p*XLEN +: XLEN]),
                64'(tbl[v].exp_rd[p*XLEN +: XLEN]));
         chk($sformatf("vec%0d rd_busy", v), 64'(rd_busy), 64'(tbl[v].exp_rb));
         @(posedge clk);
         m_commit();
         #1;
         chk($sformatf("vec%0d busy", v), 64'(busy), 64'(tbl[v].exp_busy));
         @(negedge clk);
      end
      set_idle();

      for (int i = 0; i < 400; i++) begin
         wr0_en = 1'($urandom_range(0, 1)); wr0_addr = rnd_addr(); wr0_data = $urandom;
         wr1_en = 1'($urandom_range(0, 1)); wr1_addr = rnd_addr(); wr1_data = $urandom;
         issue_en = 1'($urandom_range(0, 1)); issue_addr = rnd_addr();
         rd_addr = {rnd_addr(), rnd_addr(), rnd_addr()};
`ifdef REGS_DEBUG_PORT_EN
         dbg_addr = rnd_addr();
`endif
         model_cycle();
      end

      // Mid-run reset with x2 holding a value and a pending producer.
      set_idle();
      wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'd5;
      issue_en = 1'b1; issue_addr = 5'd2;
      rd_addr = {5'd0, 5'd1, 5'd2};
      model_cycle();
      set_idle();
      #1;
      chk("pre_rst x2", 64'(rd_data[XLEN-1:0]), 64'd5);
      chk("pre_rst busy2", 64'(busy[2]), 64'd1);
      do_reset(2);
      rd_addr = {5'd2, 5'd2, 5'd2};
      #1;
      chk("post_rst x2", 64'(rd_data[XLEN-1:0]), 64'd0);
      chk("post_rst rd_busy", 64'(rd_busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/regs_mp.md
Name: regs_mp

Overview:
- Parametrised successor to the core integer register file.
- N combinational read ports with write-to-read bypass, plus two write ports that can both commit in the same cycle.
  - wr0: execute-stage write, higher priority.
  - wr1: memory-stage write.
- Per-register pending-write scoreboard used by decode for hazard detection.
- A post-reset clear sweep zeroes every entry before the block reports ready.

Parameters:
- XLEN, 32, data width of each register.
- REG_COUNT, 32, number of architectural registers; must be a power of two, at least 2.
- READ_PORTS, 3, number of independent read ports.
- ADDR_W, $clog2(REG_COUNT), register address width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- ready  out  1  high once the clear sweep has finished.
- rd_addr  in  READ_PORTS*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  READ_PORTS*XLEN  packed read data, same packing as rd_addr.
- rd_busy  out  READ_PORTS  scoreboard busy flag for each read port's address.
- wr0_en  in  1  execute-stage write enable.
- wr0_addr  in  ADDR_W  execute-stage write address.
- wr0_data  in  XLEN  execute-stage write data.
- wr1_en  in  1  memory-stage write enable.
- wr1_addr  in  ADDR_W  memory-stage write address.
- wr1_data  in  XLEN  memory-stage write data.
- issue_en  in  1  marks a register as having a pending write.
- issue_addr  in  ADDR_W  destination register being issued.
- busy  out  REG_COUNT  full scoreboard vector.

Behaviour:
- FSM states: INIT and RUN.
- While rst is low at a clock edge:
  - state goes to INIT and the sweep counter goes to 0;
  - busy is cleared to all zeros;
  - ready is 0.
  - This applies equally when rst is asserted mid-operation.
- INIT:
  - each cycle writes 0 to data[cnt], then increments cnt;
  - when cnt == REG_COUNT-1 the next state is RUN, so the sweep takes exactly REG_COUNT cycles after rst is released;
  - wr0, wr1 and issue are ignored;
  - rd_data is 0 and rd_busy is 0.
- RUN: ready is 1.
- Writes commit at the rising edge.
  - Any write to address 0 is dropped; data[0] is always 0.
  - wr0 and wr1 to different nonzero addresses both commit in the same cycle.
  - Same address on both ports: wr0 data is stored.
- Read path is combinational (zero latency), evaluated per port.
  - rd_addr == 0 returns 0.
  - Otherwise, if wr0_en and wr0_addr match, return wr0_data.
  - Otherwise, if wr1_en and wr1_addr match, return wr1_data.
  - Otherwise return data[rd_addr].
- Scoreboard, updated at the rising edge in RUN:
  - a write on either port clears busy[addr];
  - issue_en sets busy[issue_addr];
  - if an issue and a write target the same address in the same cycle, the set wins (a new producer is pending);
  - address 0 is never marked busy.
- rd_busy[i] = busy[rd_addr_i] AND NOT (a write enable is active this cycle to rd_addr_i). This bypasses the clear in the same cycle as the write.

Optional Feature:
- Macro: REGS_DEBUG_PORT_EN.
- Defined: adds input dbg_addr [ADDR_W] and output dbg_data [XLEN].
  - dbg_data is a raw combinational read of data[dbg_addr], with no bypass.
  - dbg_data reads 0 during INIT.
- Undefined: neither port exists and no debug logic is generated.

Decomposition:
- Shared package / const include:
  - XLEN and REG_COUNT defaults;
  - state encoding (INIT=1'b0, RUN=1'b1);
  - a packed-slice helper macro for the read ports.
- Sub-module regs_bypass: one read port's zero/wr0/wr1/array priority mux plus its rd_busy computation, instantiated READ_PORTS times through a generate loop.

Test Plan:
1. Release rst after 3 low cycles → ready stays 0 for exactly 32 cycles, then goes to 1; every rd_data reads 0; busy = 0.
2. Single write, RUN: wr0 writes x5=0xDEADBEEF → rd_data for x5 is 0xDEADBEEF in the same cycle (bypass) and on the next cycle (stored).
3. Dual write:
   - wr0 writes x3=0x11 and wr1 writes x4=0x22 in the same cycle → both values are stored;
   - then wr0 writes x7=0xAA and wr1 writes x7=0xBB in the same cycle → x7 reads 0xAA.
4. Zero register: wr0 and wr1 both write 0x1234 to address 0, and issue_en targets x0 → read port on x0 returns 0 and busy[0] = 0.
5. Scoreboard:
   - issue x9 → busy[9] = 1 on the next cycle;
   - write x9 via wr1 → rd_busy for x9 reads 0 in that cycle, and busy[9] = 0 on the next cycle;
   - issue x9 and wr0-write x9 in the same cycle → busy[9] = 1.
6. Mid-run reset: assert rst with x2=5 stored and busy[2]=1 → after the sweep completes, x2 reads 0, busy is all zeros, and ready returns to 1 after 32 cycles.
